score_keeper: RTL and testbench

Game-side score and life bookkeeping for the plane-war game. Consumes hit events from the collision logic and runs the IDLE/PLAY/OVER game state. Produces the 27-bit binary value that the 8-digit seven-segment driver shows. All outputs are registered and stable between events, so the display driver can sample them on its slower clock.

---
 rtl/score_pkg.sv | 33 +++
 rtl/combo_tracker.sv | 51 +++++
 rtl/score_keeper.sv | 165 ++++++++++++++++
 tb/tb_score_keeper.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared encodings, widths and point defaults for the plane-war score keeper.
package score_pkg;

   localparam int unsigned SCORE_W = 27;
   localparam int unsigned SUM_W   = 30;

   localparam int unsigned DEF_PTS_SMALL = 10;
   localparam int unsigned DEF_PTS_BIG   = 50;
   localparam int unsigned DEF_PTS_BOSS  = 200;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } game_state_e;

   typedef enum logic [1:0] {
      HIT_SMALL = 2'd0,
      HIT_BIG   = 2'd1,
      HIT_BOSS  = 2'd2,
      HIT_RSVD  = 2'd3
   } hit_kind_e;

   // Add in a wider domain so the sum can never wrap, then clamp to the ceiling.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SUM_W-1:0]   b,
                                                  input logic [SCORE_W-1:0] lim);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + b;
      return (sum > SUM_W'(lim)) ? lim : SCORE_W'(sum);
   endfunction

endpackage

// File: rtl/combo_tracker.sv
// Combo multiplier (1..4) with an inactivity window that drops it back to 1.
module combo_tracker #(
   parameter int unsigned COMBO_WINDOW = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       hit,
   input  logic       player_hit,
   output logic [2:0] combo
);

   localparam int unsigned TIMER_W   = $clog2(COMBO_WINDOW + 1);
   localparam logic [2:0]  COMBO_MIN = 3'd1;
   localparam logic [2:0]  COMBO_MAX = 3'd4;

   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   logic [2:0]         combo_next;

   // The timer only runs while a combo is live, so it never exceeds the window.
   always_comb begin
      combo_next = combo;
      timer_next = timer;
      if (clear || player_hit) begin
         combo_next = COMBO_MIN;
         timer_next = '0;
      end else if (hit) begin
         combo_next = (combo >= COMBO_MAX) ? COMBO_MAX : 3'(combo + 3'd1);
         timer_next = '0;
      end else if (combo > COMBO_MIN) begin
         if (timer == TIMER_W'(COMBO_WINDOW - 1)) begin
            combo_next = COMBO_MIN;
            timer_next = '0;
         end else begin
            timer_next = TIMER_W'(timer + 1'b1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         combo <= COMBO_MIN;
         timer <= '0;
      end else begin
         combo <= combo_next;
         timer <= timer_next;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Game state, score/life bookkeeping and display value for the plane-war game.
module score_keeper
   import score_pkg::*;
#(
   parameter int unsigned SCORE_MAX    = 99999999,
   parameter int unsigned PTS_SMALL    = DEF_PTS_SMALL,
   parameter int unsigned PTS_BIG      = DEF_PTS_BIG,
   parameter int unsigned PTS_BOSS     = DEF_PTS_BOSS,
   parameter int unsigned COMBO_WINDOW = 100000000,
   parameter int unsigned BLINK_HALF   = 50000000,
   parameter int unsigned START_LIVES  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        hit_valid,
   input  logic [1:0]  hit_kind,
   input  logic        player_hit,
   output logic [26:0] num_show,
   output logic [1:0]  lives,
   output logic [2:0]  combo,
   output logic [1:0]  game_state,
   output logic        game_over
);

   localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

   game_state_e         state;
   game_state_e         state_next;
   logic [SCORE_W-1:0]  score;
   logic [SCORE_W-1:0]  score_next;
   logic [SCORE_W-1:0]  high_score;
   logic [SCORE_W-1:0]  high_next;
   logic [SCORE_W-1:0]  num_show_next;
   logic [1:0]          lives_next;
   logic [BLINK_W-1:0]  blink_cnt;
   logic [BLINK_W-1:0]  blink_cnt_next;
   logic                blink_phase;
   logic                blink_phase_next;
   logic                game_over_next;

   logic                clear_c;
   logic                hit_ok_c;
   logic                player_hit_ok_c;
   logic [SUM_W-1:0]    base_c;
   logic [SUM_W-1:0]    pts_c;
   logic [SCORE_W-1:0]  hit_score_c;

   combo_tracker #(
      .COMBO_WINDOW (COMBO_WINDOW)
   ) u_combo (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear_c),
      .hit        (hit_ok_c),
      .player_hit (player_hit_ok_c),
      .combo      (combo)
   );

   // Points for the current hit, multiplied by the combo held before this hit.
   always_comb begin
      base_c = '0;
      case (hit_kind_e'(hit_kind))
         HIT_SMALL: base_c = SUM_W'(PTS_SMALL);
         HIT_BIG:   base_c = SUM_W'(PTS_BIG);
         HIT_BOSS:  base_c = SUM_W'(PTS_BOSS);
         default:   base_c = '0;
      endcase
      pts_c       = base_c * SUM_W'(combo);
      hit_score_c = sat_add(score, pts_c, SCORE_W'(SCORE_MAX));
   end

   // Next-state and next-value logic; the display value is chosen from next values.
   always_comb begin
      state_next       = state;
      score_next       = score;
      lives_next       = lives;
      high_next        = high_score;
      blink_cnt_next   = blink_cnt;
      blink_phase_next = blink_phase;
      num_show_next    = num_show;
      game_over_next   = 1'b0;
      clear_c          = 1'b0;
      hit_ok_c         = 1'b0;
      player_hit_ok_c  = 1'b0;

      case (state)
         ST_IDLE: begin
            clear_c = start;
         end
         ST_PLAY: begin
            hit_ok_c        = hit_valid && (hit_kind_e'(hit_kind) != HIT_RSVD);
            player_hit_ok_c = player_hit;
            if (hit_ok_c) begin
               score_next = hit_score_c;
            end
            // A simultaneous hit is already folded into score_next here.
            if (player_hit) begin
               if (lives > 2'd1) begin
                  lives_next = 2'(lives - 2'd1);
               end else begin
                  lives_next       = 2'd0;
                  state_next       = ST_OVER;
                  high_next        = (score_next > high_score) ? score_next : high_score;
                  blink_cnt_next   = '0;
                  blink_phase_next = 1'b0;
               end
            end
         end
         ST_OVER: begin
            clear_c = start;
            if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
               blink_cnt_next   = '0;
               blink_phase_next = ~blink_phase;
            end else begin
               blink_cnt_next = BLINK_W'(blink_cnt + 1'b1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (clear_c) begin
         state_next       = ST_PLAY;
         score_next       = '0;
         lives_next       = 2'(START_LIVES);
         blink_cnt_next   = '0;
         blink_phase_next = 1'b0;
      end

      case (state_next)
         ST_IDLE: num_show_next = high_next;
         ST_PLAY: num_show_next = score_next;
         ST_OVER: num_show_next = blink_phase_next ? high_next : score_next;
         default: num_show_next = high_next;
      endcase
      game_over_next = (state_next == ST_OVER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         score       <= '0;
         high_score  <= '0;
         lives       <= 2'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         num_show    <= '0;
         game_over   <= 1'b0;
      end else begin
         state       <= state_next;
         score       <= score_next;
         high_score  <= high_next;
         lives       <= lives_next;
         blink_cnt   <= blink_cnt_next;
         blink_phase <= blink_phase_next;
         num_show    <= num_show_next;
         game_over   <= game_over_next;
      end
   end

   assign game_state = state;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized play
// compared against a cycle-stamped behavioural model of the game rules.
module tb_score_keeper;

   localparam int CW   = 8;
   localparam int BH   = 4;
   localparam int SMAX = 3000;
   localparam int LIV0 = 3;

   logic        clk;
   logic        rst;
   logic        start;
   logic        hit_valid;
   logic [1:0]  hit_kind;
   logic        player_hit;
   logic [26:0] num_show;
   logic [1:0]  lives;
   logic [2:0]  combo;
   logic [1:0]  game_state;
   logic        game_over;
   logic [34:0] dut_vec;

   int compares = 0;
   int errors   = 0;

   // Behavioural model: state 0 IDLE, 1 PLAY, 2 OVER; times are edge numbers.
   int     edge_n;
   int     m_state;
   longint m_score;
   longint m_high;
   int     m_lives;
   int     m_combo;
   int     m_last_hit;
   int     m_over_edge;

   score_keeper #(
      .SCORE_MAX    (SMAX),
      .COMBO_WINDOW (CW),
      .BLINK_HALF   (BH),
      .START_LIVES  (LIV0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .hit_valid  (hit_valid),
      .hit_kind   (hit_kind),
      .player_hit (player_hit),
      .num_show   (num_show),
      .lives      (lives),
      .combo      (combo),
      .game_state (game_state),
      .game_over  (game_over)
   );

   assign dut_vec = {num_show, lives, combo, game_state, game_over};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pts(input logic [1:0] k);
      case (k)
         2'd0:    return 10;
         2'd1:    return 50;
         2'd2:    return 200;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state     = 0;
      m_score     = 0;
      m_high      = 0;
      m_lives     = 0;
      m_combo     = 1;
      m_last_hit  = 0;
      m_over_edge = 0;
   endtask

   task automatic model_edge(input logic s, input logic hv, input logic [1:0] hk, input logic ph);
      edge_n++;
      if (m_state != 1) begin
         if (s) begin
            m_state = 1; m_score = 0; m_lives = LIV0; m_combo = 1;
         end
      end else begin
         if (hv && hk != 2'd3) begin
            m_score = m_score + longint'(pts(hk) * m_combo);
            if (m_score > SMAX) m_score = SMAX;
            m_combo    = (m_combo >= 4) ? 4 : m_combo + 1;
            m_last_hit = edge_n;
         end else if (m_combo > 1 && edge_n - m_last_hit >= CW) begin
            m_combo = 1;
         end
         if (ph) begin
            m_combo = 1;
            if (m_lives > 1) m_lives--;
            else begin
               m_lives = 0; m_state = 2; m_over_edge = edge_n;
               if (m_score > m_high) m_high = m_score;
            end
         end
      end
   endtask

   function automatic logic [34:0] exp_vec();
      longint disp;
      if (m_state == 0)      disp = m_high;
      else if (m_state == 1) disp = m_score;
      else                   disp = (((edge_n - m_over_edge) / BH) % 2 == 1) ? m_high : m_score;
      return {27'(disp), 2'(m_lives), 3'(m_combo), 2'(m_state), 1'(m_state == 2)};
   endfunction

   task automatic cycle(input logic s, input logic hv, input logic [1:0] hk, input logic ph);
      start = s; hit_valid = hv; hit_kind = hk; player_hit = ph;
      @(posedge clk);
      model_edge(s, hv, hk, ph);
      #1;
      start = 1'b0; hit_valid = 1'b0; player_hit = 1'b0; hit_kind = 2'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_kind = 2'd0; player_hit = 1'b0;
      edge_n = 0;
      model_reset();
      #1;
      compares++;
      if (dut_vec !== {27'd0, 2'd0, 3'd1, 2'd0, 1'b0}) begin
         errors++; $display("FAIL reset_values: got %h required %h", dut_vec, {27'd0, 2'd0, 3'd1, 2'd0, 1'b0});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         cycle(1'b0, 1'b1, 2'd2, 1'b1);
         compares++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL idle_ignores_events: got %h required %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_first_hit();
      cycle(1'b1, 1'b0, 2'd0, 1'b0);
      compares++;
      if (game_state !== 2'd1 || lives !== 2'd3 || num_show !== 27'd0) begin
         errors++; $display("FAIL start_play: got state %0d lives %0d show %0d required 1 3 0", game_state, lives, num_show);
      end
      cycle(1'b0, 1'b1, 2'd0, 1'b0);
      compares++;
      if (num_show !== 27'd10 || combo !== 3'd2) begin
         errors++; $display("FAIL first_hit: got show %0d combo %0d required 10 2", num_show, combo);
      end
   endtask

   task automatic test_combo_timeout();
      longint base;
      repeat (10) cycle(1'b0, 1'b0, 2'd0, 1'b0);
      compares++;
      if (combo !== 3'd1) begin
         errors++; $display("FAIL combo_decay_pre: got %0d required 1", combo);
      end
      base = m_score;
      cycle(1'b0, 1'b1, 2'd0, 1'b0);
      compares++;
      if (num_show !== 27'(base + 10) || combo !== 3'd2) begin
         errors++; $display("FAIL timeout_hit1: got show %0d combo %0d required %0d 2", num_show, combo, base + 10);
      end
      repeat (9) cycle(1'b0, 1'b0, 2'd0, 1'b0);
      compares++;
      if (combo !== 3'd1) begin
         errors++; $display("FAIL combo_window_expired: got %0d required 1", combo);
      end
      cycle(1'b0, 1'b1, 2'd0, 1'b0);
      compares++;
      if (num_show !== 27'(base + 20) || combo !== 3'd2) begin
         errors++; $display("FAIL timeout_hit2: got show %0d combo %0d required %0d 2", num_show, combo, base + 20);
      end
   endtask

   task automatic test_combo_chain();
      int exp_show [4];
      int exp_combo [4];
      exp_show  = '{50, 150, 300, 500};
      exp_combo = '{2, 3, 4, 4};
      repeat (3) cycle(1'b0, 1'b0, 2'd0, 1'b1);
      compares++;
      if (game_over !== 1'b1 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL first_game_over: got %h required %h", dut_vec, exp_vec());
      end
      cycle(1'b1, 1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 2'd1, 1'b0);
         compares++;
         if (num_show !== 27'(exp_show[i]) || combo !== 3'(exp_combo[i])) begin
            errors++; $display("FAIL combo_chain[%0d]: got show %0d combo %0d required %0d %0d",
                               i, num_show, combo, exp_show[i], exp_combo[i]);
         end
         repeat (2) cycle(1'b0, 1'b0, 2'd0, 1'b0);
      end
   endtask

   task automatic test_reserved_kind();
      cycle(1'b0, 1'b1, 2'd3, 1'b0);
      compares++;
      if (num_show !== 27'd500 || combo !== 3'd4) begin
         errors++; $display("FAIL reserved_kind: got show %0d combo %0d required 500 4", num_show, combo);
      end
   endtask

   task automatic test_game_over();
      cycle(1'b0, 1'b0, 2'd0, 1'b1);
      cycle(1'b0, 1'b0, 2'd0, 1'b1);
      cycle(1'b0, 1'b1, 2'd0, 1'b0);
      cycle(1'b0, 1'b1, 2'd2, 1'b1);
      compares++;
      if (num_show !== 27'd910 || game_over !== 1'b1 || game_state !== 2'd2 || lives !== 2'd0 || combo !== 3'd1) begin
         errors++; $display("FAIL last_life_with_hit: got %h required show 910 over", dut_vec);
      end
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b1, 2'd1, 1'b1);
         compares++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL over_hold[%0d]: got %h required %h", k, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_restart();
      int ent;
      cycle(1'b1, 1'b0, 2'd0, 1'b0);
      compares++;
      if (num_show !== 27'd0 || lives !== 2'd3 || game_state !== 2'd1 || combo !== 3'd1 || game_over !== 1'b0) begin
         errors++; $display("FAIL restart: got %h required show 0 lives 3 play", dut_vec);
      end
      cycle(1'b0, 1'b1, 2'd0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 2'd0, 1'b1);
      ent = 0;
      for (int k = 0; k < 12; k++) begin
         compares++;
         if (num_show !== ((((ent / BH) % 2) == 1) ? 27'd910 : 27'd10) || game_over !== 1'b1) begin
            errors++; $display("FAIL blink[%0d]: got show %0d over %0b required %0d 1", k, num_show, game_over,
                               (((ent / BH) % 2) == 1) ? 910 : 10);
         end
         cycle(1'b0, 1'b0, 2'd0, 1'b0);
         ent++;
      end
   endtask

   task automatic test_saturation();
      cycle(1'b1, 1'b0, 2'd0, 1'b0);
      repeat (6) cycle(1'b0, 1'b1, 2'd2, 1'b0);
      compares++;
      if (num_show !== 27'(SMAX) || combo !== 3'd4) begin
         errors++; $display("FAIL saturate: got show %0d combo %0d required %0d 4", num_show, combo, SMAX);
      end
      cycle(1'b0, 1'b1, 2'd2, 1'b0);
      compares++;
      if (num_show !== 27'(SMAX)) begin
         errors++; $display("FAIL saturate_hold: got %0d required %0d", num_show, SMAX);
      end
   endtask

   task automatic test_random();
      logic s, hv, ph;
      logic [1:0] hk;
      for (int n = 0; n < 3000; n++) begin
         s  = ($urandom_range(0, 99) < 3);
         hv = ($urandom_range(0, 99) < 35);
         ph = ($urandom_range(0, 99) < 3);
         hk = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) repeat (12) cycle(1'b0, 1'b0, 2'd0, 1'b0);
         cycle(s, hv, hk, ph);
         compares++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL random[%0d]: got %h required %h", n, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      if (m_state != 1) cycle(1'b1, 1'b0, 2'd0, 1'b0);
      cycle(1'b0, 1'b1, 2'd1, 1'b0);
      cycle(1'b0, 1'b1, 2'd1, 1'b0);
      #2 rst = 1'b1;
      #1;
      compares++;
      if (dut_vec !== {27'd0, 2'd0, 3'd1, 2'd0, 1'b0}) begin
         errors++; $display("FAIL reset_mid_play: got %h required %h", dut_vec, {27'd0, 2'd0, 3'd1, 2'd0, 1'b0});
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1'b0, 1'b0, 2'd0, 1'b0);
      compares++;
      if (dut_vec !== exp_vec()) begin
         errors++; $display("FAIL after_reset: got %h required %h", dut_vec, exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_combo_timeout();
      test_combo_chain();
      test_reserved_kind();
      test_game_over();
      test_restart();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

endmodule
